// File: rtl/pht_2bc.sv
// Bimodal PHT of 2-bit saturating counters with a 2-entry update queue.
// Define PHT_BYPASS_EN to forward a same-edge write to a colliding lookup.
module pht_2bc #(
  parameter int         INDEX_W     = 6,
  parameter int         PC_LSB      = 2,
  parameter logic [1:0] RESET_VALUE = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tbl_clear,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        pred_out_valid,
  output logic        pred_taken,
  output logic [1:0]  pred_counter,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        upd_busy
);

  localparam int ENTRIES = 1 << INDEX_W;

  typedef struct packed {
    logic [INDEX_W-1:0] idx;
    logic               taken;
  } upd_t;

  logic [1:0]         cnt_q [ENTRIES];
  upd_t               fifo_q [2];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         count;
  logic               push, pop;
  upd_t               head;
  logic [1:0]         old_val, new_val, rd_val;
  logic [INDEX_W-1:0] pred_idx, upd_idx;
  logic               unused_pc;

  assign pred_idx  = pred_pc[PC_LSB+INDEX_W-1 -: INDEX_W];
  assign upd_idx   = upd_pc[PC_LSB+INDEX_W-1 -: INDEX_W];
  assign unused_pc = ^{pred_pc, upd_pc};

  assign upd_ready = (count != 2'd2) && !tbl_clear;
  assign upd_busy  = (count != 2'd0);
  assign push      = upd_valid && upd_ready;
  assign pop       = upd_busy && !tbl_clear;
  assign head      = fifo_q[rd_ptr];

  always_comb begin
    old_val = cnt_q[head.idx];
    if (head.taken) new_val = (old_val == 2'b11) ? 2'b11 : old_val + 2'd1;
    else            new_val = (old_val == 2'b00) ? 2'b00 : old_val - 2'd1;
  end

  always_comb begin
`ifdef PHT_BYPASS_EN
    rd_val = (pop && head.idx == pred_idx) ? new_val : cnt_q[pred_idx];
`else
    rd_val = cnt_q[pred_idx];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= RESET_VALUE;
    end else if (tbl_clear) begin
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= RESET_VALUE;
    end else if (pop) begin
      cnt_q[head.idx] <= new_val;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{idx: upd_idx, taken: upd_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (tbl_clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_counter   <= '0;
    end else if (tbl_clear) begin
      pred_out_valid <= 1'b0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        pred_counter <= rd_val;
        pred_taken   <= rd_val[1];
      end
    end
  end

endmodule

// File: tb/tb_pht_2bc.sv
// Self-checking bench for pht_2bc: directed scenarios plus randomized traffic
// checked every cycle against a queue/array reference model.
module tb_pht_2bc;

`ifdef PHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int RV = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_clear = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_out_valid, pred_taken, upd_ready, upd_busy;
  logic [1:0]  pred_counter;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  pht_2bc #(.INDEX_W(6), .PC_LSB(2), .RESET_VALUE(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .tbl_clear(tbl_clear),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .pred_counter(pred_counter),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_busy(upd_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3f);
  endfunction

  // Reference model: counter array plus a queue of pending {index, outcome}
  typedef struct { int idx; int tk; } ent_t;
  int   mtab [64];
  ent_t mq [$];
  int   exp_v, exp_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      foreach (mtab[i]) mtab[i] = RV;
      mq.delete();
      exp_v = 0;
      exp_c = 0;
      chk("rst_valid", int'(pred_out_valid), 0);
      chk("rst_counter", int'(pred_counter), 0);
      chk("rst_taken", int'(pred_taken), 0);
      chk("rst_ready", int'(upd_ready), 1);
      chk("rst_busy", int'(upd_busy), 0);
    end else begin
      int   ready_m, nv, li;
      bit   popping;
      ent_t h;
      chk("m_valid", int'(pred_out_valid), exp_v);
      chk("m_counter", int'(pred_counter), exp_c);
      chk("m_taken", int'(pred_taken), exp_c / 2);
      ready_m = (mq.size() < 2 && !tbl_clear) ? 1 : 0;
      chk("m_ready", int'(upd_ready), ready_m);
      chk("m_busy", int'(upd_busy), mq.size() != 0 ? 1 : 0);
      // Effect of the coming rising edge
      popping = !tbl_clear && mq.size() > 0;
      nv = 0;
      if (popping) begin
        h = mq.pop_front();
        nv = h.tk ? (mtab[h.idx] < 3 ? mtab[h.idx] + 1 : 3)
                  : (mtab[h.idx] > 0 ? mtab[h.idx] - 1 : 0);
      end
      if (pred_valid && !tbl_clear) begin
        li = idx_of(pred_pc);
        exp_c = (BYP && popping && h.idx == li) ? nv : mtab[li];
        exp_v = 1;
      end else begin
        exp_v = 0;
      end
      if (popping) mtab[h.idx] = nv;
      if (tbl_clear) begin
        foreach (mtab[i]) mtab[i] = RV;
        mq.delete();
      end else if (upd_valid && ready_m == 1) begin
        mq.push_back('{idx: idx_of(upd_pc), tk: int'(upd_taken)});
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle();
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    tbl_clear  = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pred_valid = 1'b1;
    pred_pc    = pc;
    cyc();
    pred_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = tk;
    cyc();
    upd_valid = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("reset_valid", int'(pred_out_valid), 0);
    chk("reset_ready", int'(upd_ready), 1);
    rst_n = 1'b1;
    cyc();

    lookup(32'h100);
    chk("first_valid", int'(pred_out_valid), 1);
    chk("first_counter", int'(pred_counter), 1);
    chk("first_taken", int'(pred_taken), 0);
    cyc();
    chk("valid_drops", int'(pred_out_valid), 0);
    chk("data_holds", int'(pred_counter), 1);

    repeat (3) update(32'h100, 1'b1);
    cyc(2);
    lookup(32'h100);
    chk("sat_counter", int'(pred_counter), 3);
    chk("sat_taken", int'(pred_taken), 1);

    update(32'h40, 1'b1);
    update(32'h40, 1'b1);
    update(32'h40, 1'b0);
    update(32'h40, 1'b1);
    cyc(2);
    lookup(32'h40);
    chk("stream_counter", int'(pred_counter), 3);

    // 0x200 aliases 0x100 at INDEX_W=6, so start from a cleared table
    tbl_clear = 1'b1;
    cyc();
    tbl_clear = 1'b0;
    update(32'h200, 1'b1);
    lookup(32'h200);
    chk("collide_counter", int'(pred_counter), BYP ? 2 : 1);
    lookup(32'h200);
    chk("after_collide", int'(pred_counter), 2);

    update(32'h004, 1'b1);
    cyc();
    lookup(32'h104);
    chk("alias_counter", int'(pred_counter), 2);
    lookup(32'h008);
    chk("other_counter", int'(pred_counter), 1);

    update(32'h10, 1'b1);
    update(32'h10, 1'b1);
    cyc(2);
    lookup(32'h10);
    chk("trained_10", int'(pred_counter), 3);
    update(32'h10, 1'b0);
    upd_valid = 1'b1;
    tbl_clear = 1'b1;
    #1;
    chk("clear_ready", int'(upd_ready), 0);
    chk("clear_busy_pre", int'(upd_busy), 1);
    cyc();
    idle();
    chk("clear_busy", int'(upd_busy), 0);
    lookup(32'h10);
    chk("cleared_10", int'(pred_counter), 1);

    update(32'h10, 1'b1);
    pred_valid = 1'b1;
    upd_valid = 1'b1;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(pred_out_valid), 0);
    chk("async_counter", int'(pred_counter), 0);
    chk("async_busy", int'(upd_busy), 0);
    idle();
    cyc(2);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      pred_valid = 1'($urandom_range(0, 1));
      pred_pc    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_pc     = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      upd_taken  = 1'($urandom_range(0, 1));
      tbl_clear  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end
    idle();
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
